// File: rtl/issue_wht_mp.sv
// Wake-up history table: recent result broadcasts are retained for a bounded
// number of cycles so that issue-queue operand lookups can resolve late tags.
module issue_wht_mp #(
   parameter int DEPTH    = 4,
   parameter int NW       = 2,
   parameter int NQ       = 2,
   parameter int ROB_W    = 4,
   parameter int DATA_W   = 32,
   parameter int LIFETIME = 4
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         flush,
   input  logic [NW-1:0]                we,
   input  logic [NW*ROB_W-1:0]          din_rob,
   input  logic [NW*DATA_W-1:0]         din_value,
   input  logic [NQ*ROB_W-1:0]          qin_rob,
   input  logic [NQ-1:0]                qin_rdy,
   input  logic [NQ*DATA_W-1:0]         qin_value,
   output logic [NQ-1:0]                qout_rdy,
   output logic [NQ*DATA_W-1:0]         qout_value,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int AGE_W = (LIFETIME > 1) ? $clog2(LIFETIME) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [ROB_W-1:0]  rob_q   [DEPTH];
   logic [ROB_W-1:0]  rob_d   [DEPTH];
   logic [DATA_W-1:0] value_q [DEPTH];
   logic [DATA_W-1:0] value_d [DEPTH];
   logic [AGE_W-1:0]  age_q   [DEPTH];
   logic [AGE_W-1:0]  age_d   [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   int off;
   int slot;

   function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int k = 0; k < DEPTH; k++)
         c = c + CNT_W'(v[k]);
      return c;
   endfunction

   always_comb begin
      valid_d  = valid_q;
      rob_d    = rob_q;
      value_d  = value_q;
      age_d    = age_q;
      wr_ptr_d = wr_ptr_q;
      off      = 0;
      slot     = 0;

      // Expiry: an entry is dropped on the edge that closes its last visible cycle.
      for (int e = 0; e < DEPTH; e++) begin
         if (valid_q[e]) begin
            if (LIFETIME != 0 && age_q[e] == AGE_W'(LIFETIME-1))
               valid_d[e] = 1'b0;
            else
               age_d[e] = age_q[e] + 1'b1;
         end
      end

      // Ports are applied in ascending order, so a later port's dedup also
      // retires an entry written by an earlier port in the same cycle.
      for (int i = 0; i < NW; i++) begin
         if (we[i]) begin
            slot = (int'(wr_ptr_q) + off) % DEPTH;
            for (int e = 0; e < DEPTH; e++) begin
               if (valid_d[e] && rob_d[e] == din_rob[i*ROB_W +: ROB_W])
                  valid_d[e] = 1'b0;
            end
            for (int e = 0; e < DEPTH; e++) begin
               if (e == slot) begin
                  valid_d[e] = 1'b1;
                  rob_d[e]   = din_rob[i*ROB_W +: ROB_W];
                  value_d[e] = din_value[i*DATA_W +: DATA_W];
                  age_d[e]   = '0;
               end
            end
            off = off + 1;
         end
      end
      wr_ptr_d = PTR_W'((int'(wr_ptr_q) + off) % DEPTH);

      if (flush) begin
         valid_d  = '0;
         wr_ptr_d = '0;
         for (int e = 0; e < DEPTH; e++)
            age_d[e] = '0;
      end

      count_d = popcount(valid_d);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_q  <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int e = 0; e < DEPTH; e++)
            age_q[e] <= '0;
      end else begin
         valid_q  <= valid_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         for (int e = 0; e < DEPTH; e++)
            age_q[e] <= age_d[e];
      end
   end

   // Payload needs no reset: it is never observed while its valid bit is clear.
   always_ff @(posedge clk) begin
      for (int e = 0; e < DEPTH; e++) begin
         rob_q[e]   <= rob_d[e];
         value_q[e] <= value_d[e];
      end
   end

   // At most one valid entry per tag exists, so OR-merging hit values is exact.
   always_comb begin
      qout_rdy   = '0;
      qout_value = '0;
      for (int j = 0; j < NQ; j++) begin
         logic             hit;
         logic [DATA_W-1:0] hval;
         hit  = 1'b0;
         hval = '0;
         for (int e = 0; e < DEPTH; e++) begin
            if (valid_q[e] && rob_q[e] == qin_rob[j*ROB_W +: ROB_W]) begin
               hit  = 1'b1;
               hval = hval | value_q[e];
            end
         end
         if (qin_rdy[j]) begin
            qout_rdy[j]                   = 1'b1;
            qout_value[j*DATA_W +: DATA_W] = qin_value[j*DATA_W +: DATA_W];
         end else begin
            qout_rdy[j]                   = hit;
            qout_value[j*DATA_W +: DATA_W] = hval;
         end
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_issue_wht_mp.sv
// Directed bench for issue_wht_mp with default parameters (DEPTH=4, NW=2, NQ=2, LIFETIME=4).
module tb_issue_wht_mp;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic [1:0]  we;
   logic [7:0]  din_rob;
   logic [63:0] din_value;
   logic [7:0]  qin_rob;
   logic [1:0]  qin_rdy;
   logic [63:0] qin_value;
   logic [1:0]  qout_rdy;
   logic [63:0] qout_value;
   logic [2:0]  count;

   int checks = 0;
   int failures = 0;

   issue_wht_mp dut (
      .clk(clk), .resetn(resetn), .flush(flush), .we(we),
      .din_rob(din_rob), .din_value(din_value),
      .qin_rob(qin_rob), .qin_rdy(qin_rdy), .qin_value(qin_value),
      .qout_rdy(qout_rdy), .qout_value(qout_value), .count(count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input int p, input logic [3:0] tag, input logic [31:0] val);
      we[p] = 1'b1;
      din_rob[p*4 +: 4] = tag;
      din_value[p*32 +: 32] = val;
   endtask

   task automatic set_q(input int p, input logic [3:0] tag, input logic rdy, input logic [31:0] val);
      qin_rob[p*4 +: 4] = tag;
      qin_rdy[p] = rdy;
      qin_value[p*32 +: 32] = val;
   endtask

   task automatic idle;
      we = '0; din_rob = '0; din_value = '0; flush = 1'b0;
   endtask

   task automatic do_flush;
      idle();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      idle();
      set_wr(0, 4'd1, 32'h100);
      set_wr(1, 4'd2, 32'h200);
      set_q(0, 4'd1, 1'b1, 32'h55);
      set_q(1, 4'd2, 1'b0, 32'h66);
      tick();
      tick();
      #1;
      checks++;
      if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++;
      if (qout_rdy !== 2'b01) begin failures++; $display("FAIL reset_rdy got=%b exp=01", qout_rdy); end
      checks++;
      if (qout_value !== {32'h0, 32'h55}) begin failures++; $display("FAIL reset_value got=%h exp=%h", qout_value, {32'h0, 32'h55}); end
      resetn = 1'b1;
      idle();
      tick();
      set_q(0, 4'd1, 1'b0, 32'h0);
      #1;
      checks++;
      if (qout_rdy[0] !== 1'b0) begin failures++; $display("FAIL reset_writes_ignored got=%b exp=0", qout_rdy[0]); end
   endtask

   task automatic test_basic;
      idle();
      set_wr(0, 4'd3, 32'hCAFE);
      set_q(0, 4'd3, 1'b0, 32'h0);
      set_q(1, 4'd0, 1'b0, 32'h0);
      #1;
      checks++;
      if (qout_rdy[0] !== 1'b0 || qout_value[31:0] !== 32'h0) begin
         failures++; $display("FAIL basic_no_bypass got rdy=%b val=%h exp rdy=0 val=0", qout_rdy[0], qout_value[31:0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (qout_rdy[0] !== 1'b1 || qout_value[31:0] !== 32'hCAFE) begin
         failures++; $display("FAIL basic_hit got rdy=%b val=%h exp rdy=1 val=cafe", qout_rdy[0], qout_value[31:0]);
      end
      checks++;
      if (count !== 3'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", count); end
   endtask

   task automatic test_expiry;
      do_flush();
      set_wr(0, 4'd5, 32'h500);
      tick();
      idle();
      for (int c = 1; c <= 5; c++) begin
         logic       exp_hit;
         logic [2:0] exp_cnt;
         exp_hit = (c <= 4);
         exp_cnt = (c <= 4) ? 3'd1 : 3'd0;
         set_q(0, 4'd5, 1'b0, 32'h0);
         #1;
         checks++;
         if (qout_rdy[0] !== exp_hit) begin failures++; $display("FAIL expiry_hit cycle=%0d got=%b exp=%b", c, qout_rdy[0], exp_hit); end
         checks++;
         if (count !== exp_cnt) begin failures++; $display("FAIL expiry_count cycle=%0d got=%0d exp=%0d", c, count, exp_cnt); end
         tick();
      end
   endtask

   task automatic test_wrap;
      logic [1:0] exp_r [7];
      do_flush();
      set_wr(0, 4'd1, 32'h100); set_wr(1, 4'd2, 32'h200); tick();
      set_wr(0, 4'd3, 32'h300); set_wr(1, 4'd4, 32'h400); tick();
      set_wr(0, 4'd5, 32'h500); set_wr(1, 4'd6, 32'h600); tick();
      idle();
      exp_r[1] = 2'b00; exp_r[3] = 2'b11; exp_r[5] = 2'b11;
      for (int t = 1; t <= 5; t += 2) begin
         set_q(0, 4'(t), 1'b0, 32'h0);
         set_q(1, 4'(t+1), 1'b0, 32'h0);
         #1;
         checks++;
         if (qout_rdy !== exp_r[t]) begin failures++; $display("FAIL wrap_tags%0d_%0d got=%b exp=%b", t, t+1, qout_rdy, exp_r[t]); end
      end
      checks++;
      if (qout_value !== {32'h600, 32'h500}) begin failures++; $display("FAIL wrap_value got=%h exp=%h", qout_value, {32'h600, 32'h500}); end
      checks++;
      if (count !== 3'd4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", count); end
      // wr_ptr should now be 2: the next write replaces tag 3
      set_wr(0, 4'd7, 32'h700);
      tick();
      idle();
      set_q(0, 4'd3, 1'b0, 32'h0);
      set_q(1, 4'd4, 1'b0, 32'h0);
      #1;
      checks++;
      if (qout_rdy !== 2'b10) begin failures++; $display("FAIL wrap_ptr got=%b exp=10", qout_rdy); end
      checks++;
      if (count !== 3'd4) begin failures++; $display("FAIL wrap_ptr_count got=%0d exp=4", count); end
   endtask

   task automatic test_dedup;
      do_flush();
      set_wr(0, 4'd7, 32'h11);
      set_wr(1, 4'd7, 32'h22);
      tick();
      idle();
      set_q(0, 4'd7, 1'b0, 32'h0);
      set_q(1, 4'd7, 1'b0, 32'h0);
      #1;
      checks++;
      if (qout_rdy !== 2'b11 || qout_value !== {32'h22, 32'h22}) begin
         failures++; $display("FAIL dedup_same_cycle got rdy=%b val=%h exp rdy=11 val=%h", qout_rdy, qout_value, {32'h22, 32'h22});
      end
      checks++;
      if (count !== 3'd1) begin failures++; $display("FAIL dedup_count got=%0d exp=1", count); end
      set_wr(0, 4'd7, 32'h33);
      tick();
      idle();
      #1;
      checks++;
      if (qout_value[31:0] !== 32'h33) begin failures++; $display("FAIL dedup_rewrite got=%h exp=33", qout_value[31:0]); end
      checks++;
      if (count !== 3'd1) begin failures++; $display("FAIL dedup_rewrite_count got=%0d exp=1", count); end
   endtask

   task automatic test_flush_passthrough;
      do_flush();
      set_wr(0, 4'd1, 32'h100); set_wr(1, 4'd2, 32'h200); tick();
      idle();
      set_wr(0, 4'd3, 32'h300); tick();
      idle();
      #1;
      checks++;
      if (count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
      set_q(0, 4'd1, 1'b1, 32'hAB);
      set_q(1, 4'd1, 1'b0, 32'h0);
      #1;
      checks++;
      if (qout_rdy !== 2'b11 || qout_value !== {32'h100, 32'hAB}) begin
         failures++; $display("FAIL passthrough got rdy=%b val=%h exp rdy=11 val=%h", qout_rdy, qout_value, {32'h100, 32'hAB});
      end
      flush = 1'b1;
      set_wr(0, 4'd8, 32'h800); set_wr(1, 4'd9, 32'h900);
      tick();
      idle();
      set_q(0, 4'd8, 1'b0, 32'h0);
      set_q(1, 4'd9, 1'b0, 32'h0);
      #1;
      checks++;
      if (qout_rdy !== 2'b00 || qout_value !== 64'h0) begin failures++; $display("FAIL flush_write_discard got rdy=%b val=%h exp rdy=00 val=0", qout_rdy, qout_value); end
      set_q(0, 4'd1, 1'b0, 32'h0);
      set_q(1, 4'd3, 1'b0, 32'h0);
      #1;
      checks++;
      if (qout_rdy !== 2'b00) begin failures++; $display("FAIL flush_clear got=%b exp=00", qout_rdy); end
      checks++;
      if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
   endtask

   task automatic test_reset_priority;
      do_flush();
      set_wr(0, 4'd2, 32'h200); tick();
      idle();
      resetn = 1'b0;
      flush = 1'b1;
      set_wr(0, 4'd4, 32'h400);
      set_q(0, 4'd2, 1'b1, 32'h77);
      set_q(1, 4'd2, 1'b0, 32'h0);
      #1;
      checks++;
      if (qout_value[31:0] !== 32'h77) begin failures++; $display("FAIL rstprio_passthrough got=%h exp=77", qout_value[31:0]); end
      tick();
      resetn = 1'b1;
      idle();
      set_q(0, 4'd4, 1'b0, 32'h0);
      #1;
      checks++;
      if (qout_rdy !== 2'b00 || count !== 3'd0) begin failures++; $display("FAIL rstprio_clear got rdy=%b cnt=%0d exp rdy=00 cnt=0", qout_rdy, count); end
   endtask

   initial begin
      resetn = 1'b0;
      idle();
      qin_rob = '0; qin_rdy = '0; qin_value = '0;
      #1;
      test_reset();
      test_basic();
      test_expiry();
      test_wrap();
      test_dedup();
      test_flush_passthrough();
      test_reset_priority();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/issue_wht_mp.md
ISSUE_WHT_MP -- requirements
Module: issue_wht_mp

Interface
REQ-001 Parameter DEPTH, default 4: number of history entries; legal range NW..16.
REQ-002 Parameter NW, default 2: number of write (wake-up broadcast) ports; legal range 1..4.
REQ-003 Parameter NQ, default 2: number of query ports; legal range 1..8.
REQ-004 Parameter ROB_W, default 4: ROB tag width.
REQ-005 Parameter DATA_W, default 32: value width.
REQ-006 Parameter LIFETIME, default 4: cycles an entry stays queryable; 0 = never expires.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 resetn  input  1  synchronous, active-low reset.
REQ-009 flush  input  1  invalidates the whole table.
REQ-010 we  input  NW  per-port write valid.
REQ-011 din_rob  input  NW*ROB_W  per-port ROB tag; port i at bits [i*ROB_W +: ROB_W].
REQ-012 din_value  input  NW*DATA_W  per-port result value.
REQ-013 qin_rob  input  NQ*ROB_W  per-query source tag.
REQ-014 qin_rdy  input  NQ  per-query operand already ready.
REQ-015 qin_value  input  NQ*DATA_W  per-query operand value held by requester.
REQ-016 qout_rdy  output  NQ  per-query resolved ready.
REQ-017 qout_value  output  NQ*DATA_W  per-query resolved value.
REQ-018 count  output  $clog2(DEPTH+1)  number of valid entries, registered.

Function
REQ-019 Each entry SHALL hold valid, rob, value, and an age counter wide enough for LIFETIME.
REQ-020 Asserted we bits SHALL be packed in ascending port order into entries wr_ptr, wr_ptr+1, ... modulo DEPTH; wr_ptr SHALL advance by popcount(we) modulo DEPTH.
REQ-021 Oldest-slot overwrite: a write SHALL replace its target entry regardless of that entry's valid state.
REQ-022 A written entry SHALL become visible to queries in the cycle after the write (no same-cycle bypass) with age 0.
REQ-023 Dedup: a write SHALL clear valid of every other entry holding the same rob tag, including entries written in the same cycle by lower-numbered ports; at most one valid entry per tag SHALL exist.
REQ-024 Age SHALL increment each cycle while valid; with LIFETIME>0 an entry SHALL clear valid on the edge where age reaches LIFETIME-1, so it is queryable exactly LIFETIME cycles.
REQ-025 flush SHALL clear all valid bits and reset wr_ptr to 0 on the next edge; writes in the flush cycle SHALL be discarded.
REQ-026 Query j hit SHALL be: any valid entry with rob == qin_rob[j]; lookup SHALL be purely combinational.
REQ-027 qout_rdy[j] SHALL be 1 when qin_rdy[j]=1, else hit.
REQ-028 qout_value[j] SHALL be qin_value[j] when qin_rdy[j]=1, else the hit entry value, else all-zero.
REQ-029 count SHALL equal the number of valid entries after the edge, including dedup, expiry and overwrite effects.
REQ-030 Queries SHALL be independent; any number may hit the same entry in one cycle.

Reset
REQ-031 With resetn=0 at an edge: all valid=0, wr_ptr=0, ages=0, count=0; inputs ignored.
REQ-032 During and after reset, qout_rdy SHALL equal qin_rdy and qout_value SHALL equal qin_value where rdy, else 0.
REQ-033 Reset mid-operation SHALL take priority over flush and writes in the same cycle.

Verification
REQ-034 Basic: cycle 0 we=01, rob=3, value=0xCAFE; cycle 1 query rob=3, rdy=0 -> qout_rdy=1, value=0xCAFE; same-cycle query in cycle 0 -> rdy=0, value=0.
REQ-035 Expiry (LIFETIME=4): write rob=5 at cycle 0 -> hit in cycles 1..4, miss in cycle 5; count 1 then 0.
REQ-036 Wrap/overwrite (DEPTH=4, NW=2): write tags 1,2 / 3,4 / 5,6 in consecutive cycles -> tags 1,2 miss, 3..6 hit, count=4, wr_ptr=2.
REQ-037 Dedup: same cycle port0 rob=7 value=0x11, port1 rob=7 value=0x22 -> query 7 returns 0x22, count=1; later rewrite rob=7 value=0x33 -> returns 0x33, count=1.
REQ-038 Flush with write: table holds 3 entries, flush=1 with we=11 -> next cycle all queries miss, count=0.
REQ-039 Passthrough: qin_rdy=1, qin_value=0xAB on a hitting tag -> qout_value=0xAB.
